// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the Wishbone GPIO controller: register map,
// INT_CFG field layout and parameter sanity checks.
package gpio_ctrl_pkg;

    // Word offsets selected by WBs_ADR_i[4:2].
    typedef enum logic [2:0] {
        ADR_IN       = 3'd0,
        ADR_OUT      = 3'd1,
        ADR_OE       = 3'd2,
        ADR_OUT_SET  = 3'd3,
        ADR_OUT_CLR  = 3'd4,
        ADR_INT_EN   = 3'd5,
        ADR_INT_CFG  = 3'd6,
        ADR_INT_STAT = 3'd7
    } gpio_reg_e;

    // Narrow builds pack TYPE and POL into one INT_CFG word; wider builds
    // place POL in the upper address window (address bit 5 set).
    localparam int CFG_POL_LSB      = 16;
    localparam int CFG_PACKED_MAX_W = 16;
    localparam int GPIO_MAX_W       = 32;
    localparam int SYNC_MIN         = 2;
    localparam int SYNC_MAX         = 4;
    localparam int ADDR_MIN_W       = 6;
    localparam int HI_WIN_BIT       = 5;

    function automatic bit gpio_cfg_ok(input int width, input int sync_stages,
                                       input int addr_w);
        return (width >= 1) && (width <= GPIO_MAX_W) &&
               (sync_stages >= SYNC_MIN) && (sync_stages <= SYNC_MAX) &&
               (addr_w >= ADDR_MIN_W);
    endfunction

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/gpio_ctrl_wb_param_in_sync.sv
// Pad input synchroniser with a trailing "prev" flop and per-pin
// edge/level event detection.
module gpio_ctrl_wb_param_in_sync
    import gpio_ctrl_pkg::*;
#(
    parameter int GPIO_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [GPIO_WIDTH-1:0] pins_i,
    input  logic [GPIO_WIDTH-1:0] type_i,
    input  logic [GPIO_WIDTH-1:0] pol_i,
    output logic [GPIO_WIDTH-1:0] sync_o,
    output logic [GPIO_WIDTH-1:0] event_o
);

    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] prev_q;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] fall;
    logic [GPIO_WIDTH-1:0] edge_evt;
    logic [GPIO_WIDTH-1:0] level_evt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= pins_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

    // prev clears on reset, so a pin already high at release reports a rise.
    assign rise      = sync_o & ~prev_q;
    assign fall      = ~sync_o & prev_q;
    assign edge_evt  = (pol_i & rise) | (~pol_i & fall);
    assign level_evt = (pol_i & sync_o) | (~pol_i & ~sync_o);
    assign event_o   = (type_i & edge_evt) | (~type_i & level_evt);

endmodule

// File: rtl/gpio_ctrl_wb_param.sv
// Wishbone GPIO controller: direction control, atomic set/clear of outputs
// and synchronised inputs with per-pin edge/level interrupts.
module gpio_ctrl_wb_param
    import gpio_ctrl_pkg::*;
#(
    parameter int GPIO_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int ADDRWIDTH   = 7
) (
    input  logic                  WB_CLK,
    input  logic                  WB_RSTn,
    input  logic [ADDRWIDTH-1:0]  WBs_ADR_i,
    input  logic                  WBs_CYC_i,
    input  logic                  WBs_STB_i,
    input  logic                  WBs_WE_i,
    input  logic [3:0]            WBs_BYTE_STB_i,
    input  logic [31:0]           WBs_WR_DAT_i,
    output logic [31:0]           WBs_RD_DAT_o,
    output logic                  WBs_ACK_o,
    input  logic [GPIO_WIDTH-1:0] GPIO_i,
    output logic [GPIO_WIDTH-1:0] GPIO_o,
    output logic [GPIO_WIDTH-1:0] GPIO_oe,
    output logic                  Intr_o
);

    localparam bit CFG_PACKED = (GPIO_WIDTH <= CFG_PACKED_MAX_W);

    if (!gpio_cfg_ok(GPIO_WIDTH, SYNC_STAGES, ADDRWIDTH)) begin : g_cfg_err
        $error("gpio_ctrl_wb_param: unsupported GPIO_WIDTH/SYNC_STAGES/ADDRWIDTH");
    end

    function automatic logic [31:0] to32(input logic [GPIO_WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[GPIO_WIDTH-1:0] = v;
        return r;
    endfunction

    function automatic logic [GPIO_WIDTH-1:0] from32(input logic [31:0] v);
        return v[GPIO_WIDTH-1:0];
    endfunction

    function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    logic                  ack_q, ack_d;
    logic [31:0]           rd_dat_q, rd_dat_d;
    logic [GPIO_WIDTH-1:0] out_q, out_d;
    logic [GPIO_WIDTH-1:0] oe_q, oe_d;
    logic [GPIO_WIDTH-1:0] en_q, en_d;
    logic [GPIO_WIDTH-1:0] type_q, type_d;
    logic [GPIO_WIDTH-1:0] pol_q, pol_d;
    logic [GPIO_WIDTH-1:0] stat_q, stat_d;

    logic                  acc, wr_en, rd_en, hi_win;
    gpio_reg_e             reg_sel;
    logic [31:0]           wmask, wr_bits, cfg_word, cfg_merged, rd_word;
    logic [GPIO_WIDTH-1:0] w1c, pin_sync, pin_evt;
    logic                  unused_adr;

    // An access is taken only while ACK is low, giving a one-cycle ACK pulse.
    assign acc        = WBs_CYC_i & WBs_STB_i & ~ack_q;
    assign wr_en      = acc & WBs_WE_i;
    assign rd_en      = acc & ~WBs_WE_i;
    assign reg_sel    = gpio_reg_e'(WBs_ADR_i[4:2]);
    assign hi_win     = WBs_ADR_i[HI_WIN_BIT];
    assign unused_adr = ^WBs_ADR_i;

    assign wmask      = be_to_mask(WBs_BYTE_STB_i);
    assign wr_bits    = WBs_WR_DAT_i & wmask;
    assign cfg_word   = to32(type_q) | (to32(pol_q) << CFG_POL_LSB);
    assign cfg_merged = merge32(cfg_word, WBs_WR_DAT_i, wmask);

    gpio_ctrl_wb_param_in_sync #(
        .GPIO_WIDTH  (GPIO_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk_i   (WB_CLK),
        .rst_ni  (WB_RSTn),
        .pins_i  (GPIO_i),
        .type_i  (type_q),
        .pol_i   (pol_q),
        .sync_o  (pin_sync),
        .event_o (pin_evt)
    );

    always_comb begin
        out_d  = out_q;
        oe_d   = oe_q;
        en_d   = en_q;
        type_d = type_q;
        pol_d  = pol_q;
        w1c    = '0;
        if (wr_en && !hi_win) begin
            case (reg_sel)
                ADR_OUT:      out_d = from32(merge32(to32(out_q), WBs_WR_DAT_i, wmask));
                ADR_OE:       oe_d  = from32(merge32(to32(oe_q), WBs_WR_DAT_i, wmask));
                ADR_OUT_SET:  out_d = out_q | from32(wr_bits);
                ADR_OUT_CLR:  out_d = out_q & ~from32(wr_bits);
                ADR_INT_EN:   en_d  = from32(merge32(to32(en_q), WBs_WR_DAT_i, wmask));
                ADR_INT_CFG: begin
                    if (CFG_PACKED) begin
                        type_d = from32(cfg_merged);
                        pol_d  = from32(cfg_merged >> CFG_POL_LSB);
                    end else begin
                        type_d = from32(merge32(to32(type_q), WBs_WR_DAT_i, wmask));
                    end
                end
                ADR_INT_STAT: w1c = from32(wr_bits);
                default: ;
            endcase
        end else if (wr_en && hi_win && !CFG_PACKED && (reg_sel == ADR_INT_CFG)) begin
            pol_d = from32(merge32(to32(pol_q), WBs_WR_DAT_i, wmask));
        end
        // A new event outranks a same-cycle W1C; disabled pins only hold.
        stat_d = (stat_q & ~w1c) | (pin_evt & en_q);
    end

    always_comb begin
        rd_word = '0;
        if (!hi_win) begin
            case (reg_sel)
                ADR_IN:       rd_word = to32(pin_sync);
                ADR_OUT:      rd_word = to32(out_q);
                ADR_OE:       rd_word = to32(oe_q);
                ADR_INT_EN:   rd_word = to32(en_q);
                ADR_INT_CFG:  rd_word = CFG_PACKED ? cfg_word : to32(type_q);
                ADR_INT_STAT: rd_word = to32(stat_q);
                default:      rd_word = '0;
            endcase
        end else if (!CFG_PACKED && (reg_sel == ADR_INT_CFG)) begin
            rd_word = to32(pol_q);
        end
    end

    assign ack_d    = acc;
    assign rd_dat_d = rd_en ? rd_word : '0;

    always_ff @(posedge WB_CLK) begin
        if (!WB_RSTn) begin
            ack_q    <= 1'b0;
            rd_dat_q <= '0;
            out_q    <= '0;
            oe_q     <= '0;
            en_q     <= '0;
            type_q   <= '0;
            pol_q    <= '0;
            stat_q   <= '0;
        end else begin
            ack_q    <= ack_d;
            rd_dat_q <= rd_dat_d;
            out_q    <= out_d;
            oe_q     <= oe_d;
            en_q     <= en_d;
            type_q   <= type_d;
            pol_q    <= pol_d;
            stat_q   <= stat_d;
        end
    end

    assign WBs_ACK_o    = ack_q;
    assign WBs_RD_DAT_o = rd_dat_q;
    assign GPIO_o       = out_q;
    assign GPIO_oe      = oe_q;
    assign Intr_o       = |(stat_q & en_q);

endmodule

// File: tb/tb_gpio_ctrl_wb_param.sv
// Directed bench for gpio_ctrl_wb_param: a 32-pin build and an 8-pin build
// share the bus wires, each with its own CYC.
module tb_gpio_ctrl_wb_param;

    logic        clk = 1'b0;
    logic        rstn;
    logic [6:0]  adr;
    logic        cyc32, cyc8, stb, we;
    logic [3:0]  be;
    logic [31:0] wdat;
    logic [31:0] rd32, rd8;
    logic        ack32, ack8;
    logic [31:0] gpio_i32, gpio_o32, oe32;
    logic [7:0]  gpio_i8, gpio_o8, oe8;
    logic        intr32, intr8;
    logic [31:0] rdv;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_ctrl_wb_param #(.GPIO_WIDTH(32), .SYNC_STAGES(2), .ADDRWIDTH(7)) dut32 (
        .WB_CLK(clk), .WB_RSTn(rstn), .WBs_ADR_i(adr), .WBs_CYC_i(cyc32),
        .WBs_STB_i(stb), .WBs_WE_i(we), .WBs_BYTE_STB_i(be), .WBs_WR_DAT_i(wdat),
        .WBs_RD_DAT_o(rd32), .WBs_ACK_o(ack32), .GPIO_i(gpio_i32),
        .GPIO_o(gpio_o32), .GPIO_oe(oe32), .Intr_o(intr32)
    );

    gpio_ctrl_wb_param #(.GPIO_WIDTH(8), .SYNC_STAGES(2), .ADDRWIDTH(7)) dut8 (
        .WB_CLK(clk), .WB_RSTn(rstn), .WBs_ADR_i(adr), .WBs_CYC_i(cyc8),
        .WBs_STB_i(stb), .WBs_WE_i(we), .WBs_BYTE_STB_i(be), .WBs_WR_DAT_i(wdat),
        .WBs_RD_DAT_o(rd8), .WBs_ACK_o(ack8), .GPIO_i(gpio_i8),
        .GPIO_o(gpio_o8), .GPIO_oe(oe8), .Intr_o(intr8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One Wishbone access; ACK is expected on the first edge after the request.
    task automatic bus(input bit d8, input bit w, input logic [6:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] r);
        int lat;
        lat = 0;
        r   = 'x;
        @(posedge clk); #1;
        adr = a; we = w; be = b; wdat = d; stb = 1'b1;
        if (d8) cyc8 = 1'b1; else cyc32 = 1'b1;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (d8 ? ack8 : ack32) begin
                lat = i;
                r   = d8 ? rd8 : rd32;
            end
        end
        cyc32 = 1'b0; cyc8 = 1'b0; stb = 1'b0; we = 1'b0;
        check("ack_latency", 32'(lat), 32'd1);
    endtask

    task automatic wr32(input logic [6:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] dummy;
        bus(1'b0, 1'b1, a, b, d, dummy);
    endtask

    task automatic rd32_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, 1'b0, a, 4'hF, 32'h0, r);
        check(tag, r, exp);
    endtask

    initial begin
        rstn = 1'b0; adr = '0; cyc32 = 1'b1; cyc8 = 1'b1; stb = 1'b1; we = 1'b0;
        be = 4'hF; wdat = '0; gpio_i32 = '0; gpio_i8 = '0;

        // Reset held 3 cycles with a pending request: no ACK may appear.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_ack32", 32'(ack32), 32'd0);
            check("rst_ack8", 32'(ack8), 32'd0);
        end
        cyc32 = 1'b0; cyc8 = 1'b0; stb = 1'b0;
        rstn = 1'b1;
        check("rst_gpio_o", gpio_o32, 32'h0);
        check("rst_gpio_oe", oe32, 32'h0);
        check("rst_intr", 32'(intr32), 32'd0);
        check("rst_rd_dat", rd32, 32'h0);
        check("rst_gpio_o8", 32'(gpio_o8), 32'h0);
        check("rst_oe8", 32'(oe8), 32'h0);
        check("rst_intr8", 32'(intr8), 32'd0);
        for (int i = 0; i < 8; i++) begin
            logic [6:0] a;
            a = 7'(i * 4);
            rd32_chk("rst_read", a, 32'h0);
        end

        // Output path.
        wr32(7'h04, 32'h0000_00F0, 4'hF);
        wr32(7'h08, 32'hFFFF_FFFF, 4'hF);
        check("oe_all", oe32, 32'hFFFF_FFFF);
        check("out_init", gpio_o32, 32'h0000_00F0);
        wr32(7'h0C, 32'h0000_0001, 4'hF);
        check("out_set", gpio_o32, 32'h0000_00F1);
        wr32(7'h10, 32'h0000_0030, 4'hF);
        check("out_clr", gpio_o32, 32'h0000_00C1);
        wr32(7'h04, 32'h0000_AB00, 4'b0010);
        check("out_byte", gpio_o32, 32'h0000_ABC1);
        rd32_chk("out_read", 7'h04, 32'h0000_ABC1);
        @(posedge clk); #1;
        check("ack_pulse", 32'(ack32), 32'd0);
        rd32_chk("out_set_read", 7'h0C, 32'h0);
        rd32_chk("oe_read", 7'h08, 32'hFFFF_FFFF);

        // Rising-edge interrupt on pin 3 (TYPE/POL before enabling).
        wr32(7'h18, 32'h0000_0008, 4'hF);
        wr32(7'h38, 32'h0000_0008, 4'hF);
        wr32(7'h14, 32'h0000_0008, 4'hF);
        rd32_chk("stat_idle", 7'h1C, 32'h0);
        @(posedge clk); #1; gpio_i32[3] = 1'b1;
        @(posedge clk); #1; check("rise_c1", 32'(intr32), 32'd0);
        @(posedge clk); #1; check("rise_c2", 32'(intr32), 32'd0);
        @(posedge clk); #1; check("rise_c3", 32'(intr32), 32'd1);
        gpio_i32[3] = 1'b0;
        rd32_chk("rise_stat", 7'h1C, 32'h0000_0008);
        wr32(7'h1C, 32'h0000_0008, 4'hF);
        check("w1c_intr", 32'(intr32), 32'd0);
        rd32_chk("w1c_stat", 7'h1C, 32'h0);

        // Input synchronisation onto IN.
        gpio_i32 = 32'hA5A5_0000;
        repeat (3) @(posedge clk);
        #1;
        rd32_chk("in_read", 7'h00, 32'hA5A5_0000);
        gpio_i32 = 32'h0;
        repeat (3) @(posedge clk);

        // Level-high on pin 5, cleared while still active.
        wr32(7'h38, 32'h0000_0028, 4'hF);
        wr32(7'h14, 32'h0000_0028, 4'hF);
        gpio_i32[5] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rd32_chk("lvl_stat", 7'h1C, 32'h0000_0020);
        wr32(7'h1C, 32'h0000_0020, 4'hF);
        rd32_chk("lvl_reset", 7'h1C, 32'h0000_0020);
        check("lvl_intr", 32'(intr32), 32'd1);
        gpio_i32[5] = 1'b0;
        repeat (4) @(posedge clk);
        wr32(7'h1C, 32'h0000_0020, 4'hF);
        rd32_chk("lvl_clear", 7'h1C, 32'h0);
        check("lvl_intr_off", 32'(intr32), 32'd0);

        // Collision: rise on pin 0 and W1C of bit 0 on the same edge.
        wr32(7'h18, 32'h0000_0009, 4'hF);
        wr32(7'h38, 32'h0000_0029, 4'hF);
        wr32(7'h14, 32'h0000_0029, 4'hF);
        rd32_chk("type_read", 7'h18, 32'h0000_0009);
        rd32_chk("pol_read", 7'h38, 32'h0000_0029);
        @(posedge clk); #1; gpio_i32[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        adr = 7'h1C; we = 1'b1; be = 4'hF; wdat = 32'h1; cyc32 = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("collide_ack", 32'(ack32), 32'd1);
        cyc32 = 1'b0; stb = 1'b0; we = 1'b0;
        rd32_chk("collide_stat", 7'h1C, 32'h0000_0001);
        gpio_i32[0] = 1'b0;
        wr32(7'h1C, 32'h0000_0001, 4'hF);
        rd32_chk("collide_clr", 7'h1C, 32'h0);

        // 8-pin build: masking, packed INT_CFG and the unmapped upper window.
        bus(1'b1, 1'b1, 7'h04, 4'hF, 32'hFFFF_FFFF, rdv);
        check("w8_gpio_o", 32'(gpio_o8), 32'h0000_00FF);
        bus(1'b1, 1'b0, 7'h04, 4'hF, 32'h0, rdv);
        check("w8_out_read", rdv, 32'h0000_00FF);
        bus(1'b1, 1'b1, 7'h18, 4'hF, 32'hFFFF_FFFF, rdv);
        bus(1'b1, 1'b0, 7'h18, 4'hF, 32'h0, rdv);
        check("w8_cfg_read", rdv, 32'h00FF_00FF);
        bus(1'b1, 1'b1, 7'h18, 4'b0100, 32'h0, rdv);
        bus(1'b1, 1'b0, 7'h18, 4'hF, 32'h0, rdv);
        check("w8_cfg_be", rdv, 32'h0000_00FF);
        bus(1'b1, 1'b0, 7'h38, 4'hF, 32'h0, rdv);
        check("w8_unmapped", rdv, 32'h0);
        bus(1'b1, 1'b0, 7'h0C, 4'hF, 32'h0, rdv);
        check("w8_wo_read", rdv, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
